modulo_secded_pipeline: RTL and testbench

- Parametrised, pipelined successor to the switch-driven Hamming(8,4) SECDED path.
- Accepts a stream of extended-Hamming codewords over a valid/ready handshake and computes syndrome and overall parity.
- Corrects single-bit errors (or only flags them in detect-only mode), flags double errors, and extracts data.
- Keeps saturating error counters; sits between a codeword source (switch sampler / serial receiver) and display/LED logic.

---
 rtl/modulo_secded_pipeline.sv | 186 ++++++++++++++++++
 tb/tb_modulo_secded_pipeline.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_secded_pipeline.sv
// -----------------------------------------------------------------------------
// modulo_secded_pipeline
//   Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready
//   handshakes on both sides and saturating single/double error counters.
//
//   Codeword layout: bit 0 = overall parity, bits 1..CW-1 = Hamming positions.
//   Power-of-two positions hold parity bits.  Data bits fill the remaining
//   positions in ascending order, so data bit 0 sits at position 3.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   corr_en        1 = correct single errors, 0 = detect only (data passes raw)
//   clr_cnt        synchronous clear of both counters (beats an increment)
//   in_valid/in_ready/in_code           input codeword handshake
//   out_valid/out_ready                 output result handshake
//   out_data       extracted (optionally corrected) data
//   out_syndrome   Hamming syndrome of the word
//   out_err_single correctable error seen
//   out_err_double uncorrectable error seen
//   cnt_single     saturating count of delivered single-error words
//   cnt_double     saturating count of delivered double-error words
// -----------------------------------------------------------------------------
module modulo_secded_pipeline #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,   // minimum value with 2**PAR_W >= DATA_W+PAR_W+1
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  corr_en,
  input  logic                  clr_cnt,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W+PAR_W:0] in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [PAR_W-1:0]      out_syndrome,
  output logic                  out_err_single,
  output logic                  out_err_double,
  output logic [CNT_W-1:0]      cnt_single,
  output logic [CNT_W-1:0]      cnt_double
);

  localparam int CW = DATA_W + PAR_W + 1;

  // Stage 1: raw codeword plus its syndrome and overall parity.
  logic              s1_valid_q;
  logic [CW-1:0]     s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_par_q;
  logic              s1_corr_q;

  // Stage 2: decoded result as presented on the outputs.
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic [PAR_W-1:0]  s2_syn_q;
  logic              s2_single_q;
  logic              s2_double_q;

  logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

  logic [PAR_W-1:0]  syn_d;
  logic              par_d;
  logic [CW-1:0]     fix_code;
  logic [DATA_W:0]   data_ext;
  logic [DATA_W-1:0] data_d;
  logic              single_d;
  logic              double_d;
  logic              s2_adv;
  logic              out_fire;

  // Stage 2 can take a new word when it is empty or its word leaves this cycle;
  // stage 1 accepts when it is empty or its word moves on to stage 2.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign out_fire = s2_valid_q && out_ready;

  // Syndrome and overall parity of the incoming word.
  // NOTE: every variable driven in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    syn_d = '0;
    par_d = ^in_code;
    for (int j = 1; j < CW; j++) begin
      for (int i = 0; i < PAR_W; i++) begin
        if (((j >> i) & 1) == 1) syn_d[i] = syn_d[i] ^ in_code[j];
      end
    end
  end

  // Classification, optional correction and data extraction from stage 1.
  always_comb begin
    fix_code = s1_code_q;
    single_d = 1'b0;
    double_d = 1'b0;
    if (s1_par_q) begin
      if (s1_syn_q == '0) begin
        single_d = 1'b1;                       // only the overall parity bit flipped
      end else if (int'(s1_syn_q) <= CW - 1) begin
        single_d = 1'b1;
        if (s1_corr_q) fix_code = s1_code_q ^ (CW'(1) << s1_syn_q);
      end else begin
        double_d = 1'b1;                       // syndrome points outside the word
      end
    end else if (s1_syn_q != '0) begin
      double_d = 1'b1;
    end

    // Shift data bits in from the top so the lowest data position ends up in bit 0.
    data_ext = '0;
    data_d   = '0;
    for (int j = 1; j < CW; j++) begin
      if ((j & (j - 1)) != 0) begin
        data_ext = {fix_code[j], data_d};
        data_d   = data_ext[DATA_W:1];
      end
    end
  end

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (clr_cnt) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (out_fire) begin
      if (s2_single_q && (cnt_single_q != '1)) cnt_single_d = cnt_single_q + 1'b1;
      if (s2_double_q && (cnt_double_q != '1)) cnt_double_d = cnt_double_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well because the outputs must
      // read zero during reset; there is no memory array here to leave unreset.
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s1_corr_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_syn_q     <= '0;
      s2_single_q  <= 1'b0;
      s2_double_q  <= 1'b0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_code_q <= in_code;
          s1_syn_q  <= syn_d;
          s1_par_q  <= par_d;
          s1_corr_q <= corr_en;   // correction mode travels with the word
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q   <= data_d;
          s2_syn_q    <= s1_syn_q;
          s2_single_q <= single_d;
          s2_double_q <= double_d;
        end
      end
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_data       = s2_data_q;
  assign out_syndrome   = s2_syn_q;
  assign out_err_single = s2_single_q;
  assign out_err_double = s2_double_q;
  assign cnt_single     = cnt_single_q;
  assign cnt_double     = cnt_double_q;

endmodule

// File: tb/tb_modulo_secded_pipeline.sv
// -----------------------------------------------------------------------------
// tb_modulo_secded_pipeline
//   Drives two copies of the decoder (16-bit and 2-bit counters) with the same
//   stimulus: directed words, backpressure, counter saturation/clear, mid-stream
//   reset, then randomized traffic.  Results are compared every cycle against a
//   queue-based reference model computed from the SECDED rules.
// -----------------------------------------------------------------------------
module tb_modulo_secded_pipeline;

  localparam int DATA_W = 4;
  localparam int PAR_W  = 3;
  localparam int CW     = DATA_W + PAR_W + 1;

  logic             clk = 1'b0;
  logic             rst, corr_en, clr_cnt, in_valid, out_ready;
  logic [CW-1:0]    in_code;
  logic             in_ready, out_valid, out_err_single, out_err_double;
  logic [3:0]       out_data;
  logic [2:0]       out_syndrome;
  logic [15:0]      cnt_single, cnt_double;

  logic             d2_in_ready, d2_out_valid, d2_err_single, d2_err_double;
  logic [3:0]       d2_out_data;
  logic [2:0]       d2_out_syndrome;
  logic [1:0]       d2_cnt_single, d2_cnt_double;

  always #5 clk = ~clk;

  modulo_secded_pipeline #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .corr_en(corr_en), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_err_single(out_err_single),
    .out_err_double(out_err_double), .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  modulo_secded_pipeline #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .corr_en(corr_en), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_code(in_code),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .out_syndrome(d2_out_syndrome), .out_err_single(d2_err_single),
    .out_err_double(d2_err_double), .cnt_single(d2_cnt_single), .cnt_double(d2_cnt_double)
  );

  typedef struct {
    logic [3:0] data;
    logic [2:0] syn;
    logic       s;
    logic       d;
    int         t;      // cycle at which the word was accepted
    bit         has_k;  // directed word with hand-written expectations
    logic [3:0] k_data;
    logic [2:0] k_syn;
    logic       k_s;
    logic       k_d;
  } entry_t;

  entry_t     q[$];
  int         cyc = 0;
  int         cs = 0, cd = 0;          // unsaturated counts of delivered flagged words
  int         checks = 0, errors = 0;
  bit         last_accept;
  bit         k_has = 0;
  logic [3:0] k_data;
  logic [2:0] k_syn;
  logic       k_s, k_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: syndrome is the XOR of the indices of all set bits.
  function automatic entry_t ref_decode(input logic [CW-1:0] code, input logic corr);
    entry_t        r;
    int            syn = 0;
    int            k = 0;
    logic          par;
    logic [CW-1:0] fixed = code;
    for (int j = 1; j < CW; j++) if (code[j]) syn = syn ^ j;
    par = ^code;
    r = '{default: '0};
    if (!par && syn != 0)              r.d = 1'b1;
    else if (par && syn == 0)          r.s = 1'b1;
    else if (par && syn <= CW - 1) begin
      r.s = 1'b1;
      if (corr) fixed[syn] = ~fixed[syn];
    end else if (par)                  r.d = 1'b1;
    for (int j = 1; j < CW; j++) begin
      if (j != 1 && j != 2 && j != 4) begin
        r.data[k] = fixed[j];
        k++;
      end
    end
    r.syn = syn[2:0];
    return r;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [3:0] data);
    logic [CW-1:0] c = '0;
    int            k = 0;
    int            syn = 0;
    for (int j = 1; j < CW; j++) begin
      if (j != 1 && j != 2 && j != 4) begin
        c[j] = data[k];
        k++;
      end
    end
    for (int j = 1; j < CW; j++) if (c[j]) syn = syn ^ j;
    c[1] = syn[0];
    c[2] = syn[1];
    c[4] = syn[2];
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [CW-1:0] rand_code();
    logic [CW-1:0] c = encode(4'($urandom_range(0, 15)));
    int            a = $urandom_range(0, CW - 1);
    int            b = (a + $urandom_range(1, CW - 1)) % CW;
    case ($urandom_range(0, 3))
      0: ;
      1: c[a] = ~c[a];
      2: begin c[a] = ~c[a]; c[b] = ~c[b]; end
      default: c = CW'($urandom);
    endcase
    return c;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock cycle: check outputs against the model, clock, update the model.
  task automatic step();
    bit     exp_v, exp_rdy, in_fire, out_fire;
    entry_t e;
    #1;
    exp_v   = (q.size() > 0) && (cyc - q[0].t >= 1);
    exp_rdy = !rst && !(q.size() == 2 && !out_ready);
    check("out_valid", out_valid, exp_v);
    check("in_ready", in_ready, exp_rdy);
    if (exp_v && out_valid) begin
      check("out_data", out_data, q[0].data);
      check("out_syndrome", out_syndrome, q[0].syn);
      check("err_single", out_err_single, q[0].s);
      check("err_double", out_err_double, q[0].d);
      if (q[0].has_k) begin
        check("k_data", out_data, q[0].k_data);
        check("k_syndrome", out_syndrome, q[0].k_syn);
        check("k_single", out_err_single, q[0].k_s);
        check("k_double", out_err_double, q[0].k_d);
      end
    end
    check("cnt_single", cnt_single, sat(cs, 65535));
    check("cnt_double", cnt_double, sat(cd, 65535));
    check("cnt_single_w2", d2_cnt_single, sat(cs, 3));
    check("cnt_double_w2", d2_cnt_double, sat(cd, 3));
    in_fire  = in_valid && exp_rdy;
    out_fire = exp_v && out_ready;
    last_accept = 1'b0;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      cs = 0;
      cd = 0;
    end else begin
      if (out_fire) e = q.pop_front();
      if (clr_cnt) begin
        cs = 0;
        cd = 0;
      end else if (out_fire) begin
        cs += int'(e.s);
        cd += int'(e.d);
      end
      if (in_fire) begin
        e        = ref_decode(in_code, corr_en);
        e.t      = cyc;
        e.has_k  = k_has;
        e.k_data = k_data;
        e.k_syn  = k_syn;
        e.k_s    = k_s;
        e.k_d    = k_d;
        q.push_back(e);
        last_accept = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push_word(input logic [CW-1:0] code, input logic corr, input bit has_k,
                           input logic [3:0] kd, input logic [2:0] ks, input logic kdo,
                           input logic kdd);
    in_valid = 1'b1;
    in_code  = code;
    corr_en  = corr;
    k_has    = has_k;
    k_data   = kd;
    k_syn    = ks;
    k_s      = kdo;
    k_d      = kdd;
    for (int n = 0; n < 50; n++) begin
      step();
      if (last_accept) break;
    end
    check("accept_timeout", last_accept, 1'b1);
    in_valid = 1'b0;
    k_has    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; corr_en = 1'b1; clr_cnt = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_code = '0;
    @(posedge clk);
    #1;
    step();
    step();
    // Reset values.
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_syndrome", out_syndrome, 3'd0);
    check("rst_flags", {out_err_single, out_err_double}, 2'b00);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1'b1);

    // Directed words (data 4'hB encodes to 8'hAA).
    push_word(8'hAA, 1'b1, 1, 4'hB, 3'd0, 1'b0, 1'b0);
    push_word(8'h8A, 1'b1, 1, 4'hB, 3'd5, 1'b1, 1'b0);
    push_word(8'h8A, 1'b0, 1, 4'h9, 3'd5, 1'b1, 1'b0);
    push_word(8'hAB, 1'b1, 1, 4'hB, 3'd0, 1'b1, 1'b0);
    push_word(8'hCA, 1'b1, 1, 4'hD, 3'd3, 1'b0, 1'b1);
    repeat (3) step();
    check("dir_cnt_single", cnt_single, 16'd3);
    check("dir_cnt_double", cnt_double, 16'd1);

    // Backpressure: two words fill the pipe, the third waits.
    out_ready = 1'b0;
    push_word(8'hAA, 1'b1, 1, 4'hB, 3'd0, 1'b0, 1'b0);
    push_word(8'h8A, 1'b1, 1, 4'hB, 3'd5, 1'b1, 1'b0);
    in_valid = 1'b1; in_code = 8'hCA;
    repeat (3) step();
    check("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    push_word(8'hCA, 1'b1, 1, 4'hD, 3'd3, 1'b0, 1'b1);
    repeat (4) step();
    check("bp_cnt_single", cnt_single, 16'd4);
    check("bp_cnt_double", cnt_double, 16'd2);

    // Mid-stream reset with two words in flight.
    push_word(8'hAA, 1'b1, 0, '0, '0, 1'b0, 1'b0);
    push_word(8'h8A, 1'b1, 0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_in_ready", in_ready, 1'b0);
    check("mr_cnt_single", cnt_single, 16'd0);
    check("mr_cnt_double", cnt_double, 16'd0);
    check("mr_out_data", out_data, 4'h0);
    rst = 1'b0;
    #1;
    check("mr_rel_ready", in_ready, 1'b1);
    push_word(8'h8A, 1'b1, 1, 4'hB, 3'd5, 1'b1, 1'b0);
    check("lat_cycle1", out_valid, 1'b0);
    step();
    check("lat_cycle2", out_valid, 1'b1);
    check("lat_data", out_data, 4'hB);
    repeat (2) step();

    // Saturation of the 2-bit counters (one single already counted).
    repeat (4) push_word(8'h8A, 1'b1, 0, '0, '0, 1'b0, 1'b0);
    repeat (3) step();
    check("sat_cnt_w2", d2_cnt_single, 2'd3);
    check("sat_cnt_w16", cnt_single, 16'd5);

    // Clear on the same cycle as a single-error out handshake.
    push_word(8'h8A, 1'b1, 0, '0, '0, 1'b0, 1'b0);
    step();
    check("clr_pre_valid", out_valid, 1'b1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_cnt_single", cnt_single, 16'd0);
    check("clr_cnt_w2", d2_cnt_single, 2'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      corr_en   = 1'($urandom_range(0, 1));
      clr_cnt   = ($urandom_range(0, 99) == 0);
      in_code   = rand_code();
      step();
    end
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
